// File: rtl/mem_bus_master.sv
// Memory bus master: turns a CPU request into single or 4-beat wrapped
// memory accesses with a per-beat timeout. All outputs come straight from flops.
module mem_bus_master #(
   parameter int TIMEOUT   = 15,
   parameter int BURST_LEN = 4
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        req,
   input  logic        wr,
   input  logic        burst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        done,
   output logic        err,
   output logic        busy,
   output logic [31:0] m_a,
   output logic [31:0] m_din,
   input  logic [31:0] m_dout,
   output logic        m_strobe,
   output logic        m_rw,
   input  logic        m_ready
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
   localparam logic [1:0] LAST_BEAT    = 2'(BURST_LEN - 1);

   typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  beat_q, beat_d;
   logic [29:0] base_q, base_d;
   logic        burst_q, burst_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q, rvalid_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;
   logic [31:0] m_a_q, m_a_d;
   logic [31:0] m_din_q, m_din_d;
   logic        m_strobe_q, m_strobe_d;
   logic        m_rw_q, m_rw_d;

   logic [1:0]  next_word;
   logic        last_beat;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^addr[1:0];
   assign next_word        = base_q[1:0] + beat_q;
   assign last_beat        = !burst_q || (beat_q == LAST_BEAT);

   // Next-state logic: accept in IDLE, wait for ready or timeout in STROBE,
   // one strobe-free cycle in GAP before the next word of the line.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      beat_d     = beat_q;
      base_d     = base_q;
      burst_d    = burst_q;
      rdata_d    = rdata_q;
      rvalid_d   = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      busy_d     = busy_q;
      m_a_d      = m_a_q;
      m_din_d    = m_din_q;
      m_strobe_d = m_strobe_q;
      m_rw_d     = m_rw_q;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            // the completion cycle itself never accepts a new request
            if (req && !done_q && !err_q) begin
               state_d    = STROBE;
               burst_d    = burst & ~wr;
               base_d     = addr[31:2];
               beat_d     = 2'd0;
               cnt_d      = 8'd0;
               m_strobe_d = 1'b1;
               m_rw_d     = wr;
               m_din_d    = wdata;
               m_a_d      = {addr[31:2], 2'b00};
               busy_d     = 1'b1;
            end
         end
         STROBE: begin
            if (m_ready) begin
               m_strobe_d = 1'b0;
               cnt_d      = 8'd0;
               if (!m_rw_q) begin
                  rdata_d  = m_dout;
                  rvalid_d = 1'b1;
               end
               if (last_beat) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  beat_d  = beat_q + 2'd1;
                  state_d = GAP;
               end
            end else if (cnt_q == TIMEOUT_LAST) begin
               m_strobe_d = 1'b0;
               cnt_d      = 8'd0;
               err_d      = 1'b1;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         GAP: begin
            state_d    = STROBE;
            cnt_d      = 8'd0;
            m_strobe_d = 1'b1;
            m_a_d      = {base_q[29:2], next_word, 2'b00};
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         beat_q     <= 2'd0;
         base_q     <= 30'd0;
         burst_q    <= 1'b0;
         rdata_q    <= 32'd0;
         rvalid_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         m_a_q      <= 32'd0;
         m_din_q    <= 32'd0;
         m_strobe_q <= 1'b0;
         m_rw_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         beat_q     <= beat_d;
         base_q     <= base_d;
         burst_q    <= burst_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         done_q     <= done_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         m_a_q      <= m_a_d;
         m_din_q    <= m_din_d;
         m_strobe_q <= m_strobe_d;
         m_rw_q     <= m_rw_d;
      end
   end

   assign rdata    = rdata_q;
   assign rvalid   = rvalid_q;
   assign done     = done_q;
   assign err      = err_q;
   assign busy     = busy_q;
   assign m_a      = m_a_q;
   assign m_din    = m_din_q;
   assign m_strobe = m_strobe_q;
   assign m_rw     = m_rw_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: table of accesses run against a latency-programmable
// memory responder, with expected addresses/data held in scoreboard queues.
module tb_mem_bus_master;

   localparam int TO          = 15;
   localparam int BUDGET      = 200;
   localparam logic [31:0] GARBAGE = 32'hBAD0_BAD0;

   logic        clk = 1'b0;
   logic        clrn = 1'b0;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic        burst = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        rvalid;
   logic        done;
   logic        err;
   logic        busy;
   logic [31:0] m_a;
   logic [31:0] m_din;
   logic [31:0] m_dout = GARBAGE;
   logic        m_strobe;
   logic        m_rw;
   logic        m_ready = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   // lat = strobe cycles the responder waits before m_ready; 0 = never answers
   typedef struct {
      logic              wr;
      logic              burst;
      logic [31:0]       addr;
      logic [31:0]       wdata;
      logic [31:0]       data;
      int                lat;
      logic [3:0][31:0]  exp_a;
   } vec_t;

   vec_t vecs[10];
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];

   mem_bus_master #(.TIMEOUT(TO), .BURST_LEN(4)) dut (
      .clk(clk), .clrn(clrn), .req(req), .wr(wr), .burst(burst),
      .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
      .done(done), .err(err), .busy(busy), .m_a(m_a), .m_din(m_din),
      .m_dout(m_dout), .m_strobe(m_strobe), .m_rw(m_rw), .m_ready(m_ready)
   );

   // Free-running clock
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic w, input logic b, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] d, input int l,
                               input logic [3:0][31:0] ea);
      vec_t v;
      v.wr = w; v.burst = b; v.addr = a; v.wdata = wd; v.data = d; v.lat = l; v.exp_a = ea;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic reportFail(input string name);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: unexpected event at time %0t", name, $time);
   endtask

   task automatic applyStimulus(input vec_t v, input bit hold);
      int nb;
      bit exp_err;
      int exp_end;
      int cyc;
      int rcnt;
      int rbeat;
      int rises;
      int low_run;
      int hi_cycles;
      bit prev_strobe;
      bit finished;
      nb      = (v.burst && !v.wr) ? 4 : 1;
      exp_err = (v.lat == 0);
      exp_end = exp_err ? TO + 1 : nb * (v.lat + 1);
      for (int i = 0; i < nb; i++) begin
         exp_addr_q.push_back(v.exp_a[i]);
         if (!v.wr && !exp_err) exp_data_q.push_back(v.data + 32'(i));
      end
      req = 1'b1; wr = v.wr; burst = v.burst; addr = v.addr; wdata = v.wdata;
      @(posedge clk);
      rcnt = 0; rbeat = 0; rises = 0; low_run = 0; hi_cycles = 0;
      prev_strobe = 1'b0; finished = 1'b0; cyc = 0;
      while (!finished && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         if (!hold) req = 1'b0;
         checkOutput("busy_during", busy, 1'b1);
         if (m_strobe) hi_cycles++;
         if (m_strobe && !prev_strobe) begin
            if (exp_addr_q.size() == 0) reportFail("extra_strobe");
            else checkOutput("m_a", m_a, exp_addr_q.pop_front());
            checkOutput("m_rw", m_rw, v.wr);
            if (v.wr) checkOutput("m_din", m_din, v.wdata);
            if (rises > 0) checkOutput("gap_len", 32'(low_run), 32'd1);
            rises++;
         end
         if (!m_strobe) low_run++; else low_run = 0;
         if (rvalid) begin
            if (exp_data_q.size() == 0) reportFail("unexpected_rvalid");
            else checkOutput("rdata", rdata, exp_data_q.pop_front());
         end
         if (done || err) begin
            finished = 1'b1;
            checkOutput("end_cycle", 32'(cyc), 32'(exp_end));
            checkOutput("done", done, !exp_err);
            checkOutput("err", err, exp_err);
            checkOutput("strobe_low_at_end", m_strobe, 1'b0);
            if (!v.wr && !exp_err) checkOutput("rvalid_with_done", rvalid, 1'b1);
            if (exp_err) checkOutput("strobe_cycles", 32'(hi_cycles), 32'(TO));
         end
         prev_strobe = m_strobe;
         // responder: answers after lat strobe cycles, junk data otherwise
         m_ready = 1'b0;
         m_dout  = GARBAGE;
         if (m_strobe && v.lat != 0) begin
            rcnt++;
            if (rcnt == v.lat) begin
               m_ready = 1'b1;
               m_dout  = v.data + 32'(rbeat);
               rbeat++;
               rcnt = 0;
            end
         end
      end
      m_ready = 1'b0;
      m_dout  = GARBAGE;
      if (!finished) reportFail("access_timeout_bound");
      checkOutput("sb_addr_left", 32'(exp_addr_q.size()), 32'd0);
      checkOutput("sb_data_left", 32'(exp_data_q.size()), 32'd0);
      exp_addr_q.delete();
      exp_data_q.delete();
      @(negedge clk);
      checkOutput("busy_after", busy, 1'b0);
      checkOutput("strobe_after", m_strobe, 1'b0);
      checkOutput("done_after", done, 1'b0);
      checkOutput("err_after", err, 1'b0);
   endtask

   initial begin
      int rises;
      bit seen;
      bit prev;
      vecs[0] = mk(0, 0, 32'h2000_0008, 32'h0, 32'hDEAD_BEEF, 6,
                   {32'h0, 32'h0, 32'h0, 32'h2000_0008});
      vecs[1] = mk(1, 0, 32'h1000_0004, 32'h1234_5678, 32'h0, 3,
                   {32'h0, 32'h0, 32'h0, 32'h1000_0004});
      vecs[2] = mk(1, 1, 32'h1000_0028, 32'hCAFE_F00D, 32'h0, 2,
                   {32'h0, 32'h0, 32'h0, 32'h1000_0028});
      vecs[3] = mk(0, 1, 32'h0000_0018, 32'h0, 32'h0000_0100, 2,
                   {32'h14, 32'h10, 32'h1C, 32'h18});
      vecs[4] = mk(0, 1, 32'h0000_0013, 32'h0, 32'h0000_0200, 1,
                   {32'h1C, 32'h18, 32'h14, 32'h10});
      vecs[5] = mk(0, 0, 32'h3000_000C, 32'h0, 32'h0, 0,
                   {32'h0, 32'h0, 32'h0, 32'h3000_000C});
      vecs[6] = mk(0, 1, 32'hFFFF_FFFC, 32'h0, 32'h7000_0000, 4,
                   {32'hFFFF_FFF8, 32'hFFFF_FFF4, 32'hFFFF_FFF0, 32'hFFFF_FFFC});
      vecs[7] = mk(0, 0, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, TO,
                   {32'h0, 32'h0, 32'h0, 32'h0000_0040});
      vecs[8] = mk(1, 0, 32'h0000_0080, 32'hA5A5_5A5A, 32'h0, TO - 1,
                   {32'h0, 32'h0, 32'h0, 32'h0000_0080});
      vecs[9] = mk(0, 1, 32'h0000_0104, 32'h0, 32'h1111_0000, TO,
                   {32'h100, 32'h10C, 32'h108, 32'h104});

      // reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_m_strobe", m_strobe, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_err", err, 1'b0);
      checkOutput("rst_rvalid", rvalid, 1'b0);
      checkOutput("rst_m_a", m_a, 32'd0);
      checkOutput("rst_rdata", rdata, 32'd0);
      clrn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) applyStimulus(vecs[i], 1'b0);
      checkOutput("rdata_hold_after_write", rdata, 32'h1111_0003);

      // reset while the second beat of a burst is on the bus
      req = 1'b1; wr = 1'b0; burst = 1'b1; addr = 32'h0000_0048;
      @(posedge clk);
      rises = 0; prev = 1'b0;
      for (int c = 0; c < 40 && rises < 2; c++) begin
         @(negedge clk);
         req = 1'b0;
         if (m_strobe && !prev) rises++;
         prev = m_strobe;
         m_ready = (m_strobe && rises == 1 && c == 4);
         m_dout  = m_ready ? 32'h4444_4444 : GARBAGE;
      end
      m_ready = 1'b0;
      m_dout  = GARBAGE;
      checkOutput("second_beat_reached", 32'(rises), 32'd2);
      checkOutput("second_beat_addr", m_a, 32'h0000_004C);
      clrn = 1'b0;
      @(negedge clk);
      clrn = 1'b1;
      checkOutput("midrst_m_strobe", m_strobe, 1'b0);
      checkOutput("midrst_busy", busy, 1'b0);
      checkOutput("midrst_m_a", m_a, 32'd0);
      checkOutput("midrst_rdata", rdata, 32'd0);
      checkOutput("midrst_rvalid", rvalid, 1'b0);
      seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (done || err || rvalid || m_strobe) seen = 1'b1;
      end
      checkOutput("midrst_quiet", seen, 1'b0);
      applyStimulus(vecs[3], 1'b0);

      // req held high: second request starts only after the first finishes
      applyStimulus(mk(0, 0, 32'h0000_0500, 32'h0, 32'h0000_0050, 2,
                       {32'h0, 32'h0, 32'h0, 32'h0000_0500}), 1'b1);
      addr = 32'h0000_0600;
      @(negedge clk);
      checkOutput("hold_second_strobe", m_strobe, 1'b1);
      checkOutput("hold_second_addr", m_a, 32'h0000_0600);
      checkOutput("hold_second_busy", busy, 1'b1);
      req = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         m_ready = m_strobe;
         m_dout  = m_strobe ? 32'h5555_AAAA : GARBAGE;
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      m_ready = 1'b0;
      m_dout  = GARBAGE;
      checkOutput("hold_second_done", seen, 1'b1);
      checkOutput("hold_second_rdata", rdata, 32'h5555_AAAA);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
